// File: rtl/muldiv_execute_unit_pkg.sv
// Shared RV32M instruction constants and small decode helpers for the
// multiply/divide execute unit.
package muldiv_execute_unit_pkg;

  // Major opcode (OP) and funct7 value that select the M extension.
  localparam logic [6:0] RV32M_OPCODE = 7'b0110011;
  localparam logic [6:0] RV32M_FUNCT7 = 7'b0000001;

  // funct3 encodings of the eight M-extension operations.
  localparam logic [2:0] RV32M_MUL    = 3'd0;
  localparam logic [2:0] RV32M_MULH   = 3'd1;
  localparam logic [2:0] RV32M_MULHSU = 3'd2;
  localparam logic [2:0] RV32M_MULHU  = 3'd3;
  localparam logic [2:0] RV32M_DIV    = 3'd4;
  localparam logic [2:0] RV32M_DIVU   = 3'd5;
  localparam logic [2:0] RV32M_REM    = 3'd6;
  localparam logic [2:0] RV32M_REMU   = 3'd7;

  // True when an OP-format instruction belongs to the M extension.
  function automatic logic is_rv32m(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == RV32M_OPCODE) && (funct7 == RV32M_FUNCT7);
  endfunction

  // Divide and remainder ops all have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM treat their operands as two's complement.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return (f3 == RV32M_DIV) || (f3 == RV32M_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == RV32M_REM) || (f3 == RV32M_REMU);
  endfunction

endpackage

// File: rtl/muldiv_execute_unit_div.sv
// Unsigned XLEN-bit serial restoring divider, one quotient bit per cycle.
// The start cycle performs iteration 0 directly on the incoming operands,
// so the final quotient/remainder are registered on the edge where done
// is high. Sign handling and special cases belong to the parent.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  quo_q, rem_q, dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [XLEN-1:0]  quo_src, rem_src, dsr_src;
  logic [XLEN:0]    partial, diff;
  logic             fits;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    dsr_src = start ? divisor : dsr_q;
    partial = {rem_src, quo_src[XLEN-1]};
    diff    = partial - {1'b0, dsr_src};
    fits    = ~diff[XLEN];
  end

  // Iteration registers; cnt_q is the index of the iteration in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start || run_q) begin
      quo_q <= {quo_src[XLEN-2:0], fits};
      rem_q <= fits ? diff[XLEN-1:0] : partial[XLEN-1:0];
      dsr_q <= dsr_src;
      cnt_q <= start ? CNT_W'(1) : cnt_q + 1'b1;
      run_q <= start ? 1'b1 : (cnt_q != LAST);
    end
  end

  assign done      = run_q && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_execute_unit.sv
// RV32M multi-cycle execute unit: pipelined multiplier plus serial divider
// behind valid/ready handshakes, one operation in flight, flushable.
// Latencies counted from the accept cycle: multiply MUL_STAGES, divide
// XLEN+1, early-out special divides 1.
module muldiv_execute_unit
  import muldiv_execute_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int EARLY_OUT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t state_q, state_d;
  logic   accept;

  // Registered request and bookkeeping
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] op1_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      mul_cnt_q;
  logic            neg_quo_q, neg_rem_q, dz_q, ovf_q;

  // Incoming-request decode
  logic            in_is_div, in_signed, in_sign1, in_sign2;
  logic            in_dz, in_ovf, early;
  logic [XLEN-1:0] in_abs1, in_abs2, in_special_res;

  // Multiplier
  logic              mul_a_signed, mul_b_signed, mul_last;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0]   product_sel, mul_tail;

  // Divider
  logic [XLEN-1:0] div_quo, div_rem, quo_signed, rem_signed, div_fixed;
  logic            div_done;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == DONE) && !flush;
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign rd_out    = rd_q;

  // Decode the raw request: absolute values, result signs, special divides.
  always_comb begin
    in_is_div = is_div_op(funct3);
    in_signed = is_signed_div(funct3);
    in_sign1  = in_signed & operand1[XLEN-1];
    in_sign2  = in_signed & operand2[XLEN-1];
    in_abs1   = in_sign1 ? -operand1 : operand1;
    in_abs2   = in_sign2 ? -operand2 : operand2;
    in_dz     = (operand2 == '0);
    in_ovf    = in_signed && (operand1 == INT_MIN) && (operand2 == ALL_ONES);
    early     = (EARLY_OUT != 0) && in_is_div && (in_dz || in_ovf);
    if (in_dz)
      in_special_res = is_rem_op(funct3) ? operand1 : ALL_ONES;
    else
      in_special_res = is_rem_op(funct3) ? '0 : operand1;
  end

  // Full 2*XLEN-bit product with per-op sign extension, then half select.
  always_comb begin
    mul_a_signed = (funct3 == RV32M_MULH) || (funct3 == RV32M_MULHSU);
    mul_b_signed = (funct3 == RV32M_MULH);
    mul_a        = {{XLEN{mul_a_signed & operand1[XLEN-1]}}, operand1};
    mul_b        = {{XLEN{mul_b_signed & operand2[XLEN-1]}}, operand2};
    product      = mul_a * mul_b;
    product_sel  = (funct3 == RV32M_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // The product register captures on accept; result_q is the last stage.
  // A single-stage multiplier therefore writes result_q directly.
  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_tail = product_sel;
    end else begin : g_mul_pipe
      logic [XLEN-1:0] pipe_q [MUL_STAGES-1];

      // NOTE: pure datapath stages carry no reset; the FSM never reads them
      // before an accept has written them.
      always_ff @(posedge clk) begin
        if (accept) pipe_q[0] <= product_sel;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end

      assign mul_tail = pipe_q[MUL_STAGES-2];
    end
  endgenerate

  assign mul_last = (mul_cnt_q == 3'(MUL_STAGES - 2));

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && in_is_div && !early),
    .abort     (flush),
    .dividend  (in_abs1),
    .divisor   (in_abs2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Sign correction and ISA-defined overrides for the divide result.
  always_comb begin
    quo_signed = neg_quo_q ? -div_quo : div_quo;
    rem_signed = neg_rem_q ? -div_rem : div_rem;
    if (dz_q)
      div_fixed = is_rem_op(funct3_q) ? op1_q : ALL_ONES;
    else if (ovf_q)
      div_fixed = is_rem_op(funct3_q) ? '0 : op1_q;
    else
      div_fixed = is_rem_op(funct3_q) ? rem_signed : quo_signed;
  end

  // Next-state logic; flush overrides accept and retire.
  always_comb begin
    // NOTE: assign the default first so no path through the case infers a latch.
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (in_is_div)            state_d = early ? DONE : DIV;
          else if (MUL_STAGES == 1) state_d = DONE;
          else                      state_d = MUL;
        end
        MUL:  if (mul_last)  state_d = DONE;
        DIV:  if (div_done)  state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture, multiply stage counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q  <= '0;
      op1_q     <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      mul_cnt_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q  <= funct3;
        op1_q     <= operand1;
        rd_q      <= rd_in;
        mul_cnt_q <= '0;
        neg_quo_q <= in_sign1 ^ in_sign2;
        neg_rem_q <= in_sign1;
        dz_q      <= in_dz;
        ovf_q     <= in_ovf;
      end else if (state_q == MUL) begin
        mul_cnt_q <= mul_cnt_q + 1'b1;
      end
      if ((state_d == DONE) && (state_q != DONE)) begin
        case (state_q)
          IDLE:    result_q <= in_is_div ? in_special_res : mul_tail;
          MUL:     result_q <= mul_tail;
          FIX:     result_q <= div_fixed;
          default: result_q <= result_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_execute_unit.sv
// Directed self-checking bench for muldiv_execute_unit (XLEN=32,
// MUL_STAGES=2, EARLY_OUT=1). Latency is the count of rising edges from
// the accept edge (inclusive) until out_valid is seen high.
module tb_muldiv_execute_unit;
  import muldiv_execute_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] operand1, operand2, result;
  logic [4:0]  rd_in, rd_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  muldiv_execute_unit #(.XLEN(32), .MUL_STAGES(2), .EARLY_OUT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .operand1  (operand1),
    .operand2  (operand2),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .busy      (busy)
  );

  // Present one request for a single cycle, then scramble the inputs.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1; funct3 = f3; operand1 = a; operand2 = b; rd_in = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; funct3 = 3'd0; operand1 = 32'hDEAD_BEEF; operand2 = 32'h1234_5678;
    rd_in = 5'd31;
  endtask

  // Wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (lat < 0) begin
        @(negedge clk);
        if (out_valid === 1'b1) lat = k;
        else if (busy !== 1'b1) busy_ok = 1'b0;
      end
    end
  endtask

  task automatic retire();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = 3'd0; operand1 = '0; operand2 = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd0) $display("FAIL reset_result: got %h expected 0", result); else pass_cnt++;
    total_cnt++; if (rd_out !== 5'd0) $display("FAIL reset_rd_out: got %0d expected 0", rd_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [4];
    logic [31:0] a [4], b [4], exp [4];
    logic [4:0]  exp_rd;
    int lat;
    bit bok;
    f3  = '{RV32M_MUL, RV32M_MULH, RV32M_MULHSU, RV32M_MULHU};
    a   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    b   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      exp_rd = 5'(5 + i);
      issue(f3[i], a[i], b[i], exp_rd);
      wait_valid(lat, bok);
      total_cnt++; if (result !== exp[i]) $display("FAIL mul_result[%0d]: got %h expected %h", i, result, exp[i]); else pass_cnt++;
      total_cnt++; if (rd_out !== exp_rd) $display("FAIL mul_rd_out[%0d]: got %0d expected %0d", i, rd_out, exp_rd); else pass_cnt++;
      total_cnt++; if (lat != 2) $display("FAIL mul_latency[%0d]: got %0d expected 2", i, lat); else pass_cnt++;
      retire();
    end
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mul_in_ready_after: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4];
    logic [31:0] a [4], b [4], exp [4];
    int lat;
    bit bok;
    f3  = '{RV32M_DIV, RV32M_REM, RV32M_DIVU, RV32M_REMU};
    a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    b   = '{32'd2, 32'd2, 32'd7, 32'd7};
    exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i], 5'(10 + i));
      wait_valid(lat, bok);
      total_cnt++; if (result !== exp[i]) $display("FAIL div_result[%0d]: got %h expected %h", i, result, exp[i]); else pass_cnt++;
      total_cnt++; if (lat != 33) $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); else pass_cnt++;
      total_cnt++; if (!bok) $display("FAIL div_busy[%0d]: got 0 expected 1 while in flight", i); else pass_cnt++;
      retire();
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [4];
    logic [31:0] a [4], b [4], exp [4];
    int lat;
    bit bok;
    f3  = '{RV32M_DIVU, RV32M_REMU, RV32M_DIV, RV32M_REM};
    a   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i], 5'(20 + i));
      wait_valid(lat, bok);
      total_cnt++; if (result !== exp[i]) $display("FAIL special_result[%0d]: got %h expected %h", i, result, exp[i]); else pass_cnt++;
      total_cnt++; if (lat != 1) $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); else pass_cnt++;
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit bok;
    out_ready = 1'b0;
    issue(RV32M_DIVU, 32'd100, 32'd7, 5'd3);
    wait_valid(lat, bok);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'd14) $display("FAIL bp_result[%0d]: got %h expected %h", i, result, 32'd14); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); else pass_cnt++;
    end
    out_ready = 1'b1;
    retire();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_retired_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_retired_in_ready: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat;
    bit bok;
    bit saw_valid;
    issue(RV32M_DIVU, 32'd100, 32'd7, 5'd4);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_mid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_mid_busy: got %b expected 0", busy); else pass_cnt++;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid) $display("FAIL flush_mid_no_result: got out_valid=1 expected 0"); else pass_cnt++;
    issue(RV32M_MUL, 32'd3, 32'd4, 5'd7);
    wait_valid(lat, bok);
    total_cnt++; if (result !== 32'd12) $display("FAIL flush_then_mul: got %h expected %h", result, 32'd12); else pass_cnt++;
    total_cnt++; if (lat != 2) $display("FAIL flush_then_mul_latency: got %0d expected 2", lat); else pass_cnt++;
    retire();
    // Flush while the result is waiting in DONE with out_ready high.
    out_ready = 1'b0;
    issue(RV32M_MUL, 32'd5, 32'd6, 5'd8);
    wait_valid(lat, bok);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_done_valid: got %b expected 0", out_valid); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_done_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    saw_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid) $display("FAIL flush_done_dropped: got out_valid=1 expected 0"); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit bok;
    bit saw_valid;
    issue(RV32M_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd0) $display("FAIL rstmid_result: got %h expected 0", result); else pass_cnt++;
    total_cnt++; if (rd_out !== 5'd0) $display("FAIL rstmid_rd_out: got %0d expected 0", rd_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    total_cnt++; if (saw_valid) $display("FAIL rstmid_no_result: got out_valid=1 expected 0"); else pass_cnt++;
    issue(RV32M_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_valid(lat, bok);
    total_cnt++; if (result !== 32'hFFFF_FFFF) $display("FAIL rstmid_rem: got %h expected %h", result, 32'hFFFF_FFFF); else pass_cnt++;
    total_cnt++; if (rd_out !== 5'd11) $display("FAIL rstmid_rem_rd: got %0d expected 11", rd_out); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL rstmid_rem_latency: got %0d expected 33", lat); else pass_cnt++;
    retire();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_execute_unit.md
Name: muldiv_execute_unit

Overview:
Multi-cycle RV32M execute unit that runs beside the single-cycle integer execute stage.
- Performs MUL/MULH/MULHSU/MULHU through a parametrised pipelined multiplier.
- Performs DIV/DIVU/REM/REMU through a 1-bit-per-cycle restoring divider.
- Connects to the pipeline with valid/ready handshakes on both sides and has a flush input.
- Holds one operation in flight at a time. The pipeline stalls the EX stage while `busy` is high.

Parameters:
- XLEN, 32: operand and result width. Legal values are 32 and 64.
- MUL_STAGES, 2: multiplier latency in cycles. Legal range is 1..4.
- EARLY_OUT, 1: when 1, divide-by-zero and signed overflow complete in 1 cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  aborts the in-flight operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  M-extension operation select.
- operand1  in  XLEN  rs1 value.
- operand2  in  XLEN  rs2 value.
- rd_in  in  5  destination register.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- result  out  XLEN  operation result.
- rd_out  out  5  destination register of the result.
- busy  out  1  operation accepted and not yet retired.

Behaviour:
- Reset state after rst: state=IDLE, out_valid=0, result=0, rd_out=0, busy=0, in_ready=1.
- Reset aborts any operation in progress and produces no output.
- funct3 encoding:
  - 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
  - 4=DIV, 5=DIVU, 6=REM, 7=REMU.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE).
- Accept happens when in_valid && in_ready && !flush. On accept, the unit registers funct3, operands and rd_in.
- Multiply path:
  - IDLE→MUL on accept.
  - MUL forms a 2*XLEN-bit product with operand sign-extension per op:
    - MULH: both operands signed.
    - MULHSU: operand1 signed, operand2 unsigned.
    - MULHU and MUL: both operands unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - out_valid rises exactly MUL_STAGES cycles after the accept edge.
- Divide path:
  - IDLE→DIV on accept.
  - Signed ops (DIV/REM) take absolute values on entry and record the result signs:
    - quotient sign = sign1 XOR sign2.
    - remainder sign = sign1.
  - DIV runs exactly XLEN iterations using an internal counter 0..XLEN-1, then moves to FIX.
  - FIX applies the sign correction, then moves to DONE.
  - out_valid rises XLEN+1 cycles after the accept edge.
- Special cases (results fixed by the ISA):
  - Divisor 0: quotient = all ones, remainder = operand1.
  - Signed overflow (operand1 = -2^(XLEN-1), operand2 = -1): quotient = operand1, remainder = 0.
  - With EARLY_OUT=1, these go IDLE→DONE and out_valid rises 1 cycle after accept.
  - With EARLY_OUT=0, they take the full divide latency and produce the same values.
- DONE state:
  - out_valid = (state==DONE) && !flush.
  - result and rd_out stay stable while out_valid && !out_ready.
  - When out_valid && out_ready, state→IDLE. in_ready=1 the following cycle; there is no same-cycle re-accept.
- busy = (state != IDLE).
- Flush:
  - Flush has priority over accept and retire.
  - Any state→IDLE next cycle, with no result produced.
  - If flush is high in DONE, the result is dropped even if out_ready is high.
- Inputs are sampled only on accept. Operand changes after accept have no effect.

Decomposition:
- Shared instruction package: RV32M funct3 constants (RV32M_MUL ... RV32M_REMU) and the RV32M opcode/funct7 (0000001) constants.
- Local typedef enum for the state (IDLE/MUL/DIV/FIX/DONE).
- One sub-module, muldiv_div_core: an unsigned XLEN-bit serial restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done after XLEN cycles.
  - Sign handling and special cases stay in the parent.
- The multiplier is inline: a product register followed by MUL_STAGES-1 delay registers.

Test Plan (XLEN=32, MUL_STAGES=2, EARLY_OUT=1):
- MUL 7 × 0xFFFFFFFD, rd=5 → result 0xFFFFFFEB and rd_out 5, out_valid 2 cycles after accept. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 ÷ 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 ÷ 7 → 14. REMU 100 ÷ 7 → 2. out_valid exactly 33 cycles after accept; busy=1 throughout.
- DIVU 5 ÷ 0 → 0xFFFFFFFF and REMU → 5. DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000 and REM → 0. Each case gives out_valid 1 cycle after accept.
- Backpressure: DIV 100 ÷ 7 with out_ready=0 for 5 cycles after out_valid → result 14 held stable, in_ready=0. Raise out_ready → retire; in_ready=1 the next cycle.
- Flush mid-operation: flush at cycle 10 of a DIV → out_valid never asserts, in_ready=1 next cycle; a following MUL 3×4 returns 12. Flush in DONE with out_ready=1 → no result handshake.
- rst asserted mid-DIV → all outputs return to reset values next cycle; a subsequent REM 0xFFFFFFF9 ÷ 2 returns 0xFFFFFFFF.
